// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer for a 4x4 systolic array: clears, feeds skewed A/B lanes,
// drains the wavefront and streams each output tile row-by-row to the result buffer.
module systolic_tile_sequencer #(
    parameter int MATRIX_SIZE = 8,
    parameter int ARRAY_SIZE  = 4,
    parameter int ADDR_W      = 6
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          res_ready,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          pe_clear,
    output logic                                          pe_en,
    output logic [ARRAY_SIZE-1:0]                         a_valid,
    output logic [ARRAY_SIZE-1:0]                         b_valid,
    output logic [ARRAY_SIZE*ADDR_W-1:0]                  a_addr,
    output logic [ARRAY_SIZE*ADDR_W-1:0]                  b_addr,
    output logic                                          res_we,
    output logic [$clog2(ARRAY_SIZE)-1:0]                 res_row,
    output logic [ADDR_W-1:0]                             res_addr,
    output logic [$clog2((MATRIX_SIZE/ARRAY_SIZE)**2)-1:0] tile_idx
);

    localparam int N         = MATRIX_SIZE;
    localparam int A         = ARRAY_SIZE;
    localparam int T         = N / A;
    localparam int FEED_LEN  = N + A - 1;
    localparam int DRAIN_LEN = 2 * (A - 1);
    localparam int CNT_W     = $clog2(FEED_LEN + 1);
    localparam int TR_W      = (T > 1) ? $clog2(T) : 1;
    localparam int RW        = $clog2(A);
    localparam int TI_W      = $clog2(T * T);

    if (MATRIX_SIZE % ARRAY_SIZE != 0) begin : g_bad_size
        $error("MATRIX_SIZE must be a multiple of ARRAY_SIZE");
    end
    if ((2 ** ADDR_W) < MATRIX_SIZE * MATRIX_SIZE) begin : g_bad_addr
        $error("ADDR_W too narrow for MATRIX_SIZE^2 words");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_STORE, S_NEXT, S_FIN
    } state_t;

    state_t             state_q, nxt_state;
    logic [CNT_W-1:0]   t_q, nxt_t;
    logic [RW-1:0]      r_q, nxt_r;
    logic [TR_W-1:0]    row_q, nxt_row, col_q, nxt_col;

    logic [A-1:0]        av_n;
    logic [A*ADDR_W-1:0] aa_n, ba_n;
    logic [ADDR_W-1:0]   raddr_n;

    always_comb begin
        nxt_state = state_q;
        nxt_t     = t_q;
        nxt_r     = r_q;
        nxt_row   = row_q;
        nxt_col   = col_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    nxt_state = S_CLEAR;
                    nxt_row   = '0;
                    nxt_col   = '0;
                end
            end
            S_CLEAR: begin
                nxt_state = S_FEED;
                nxt_t     = '0;
            end
            S_FEED: begin
                if (t_q == CNT_W'(FEED_LEN - 1)) begin
                    nxt_state = S_DRAIN;
                    nxt_t     = '0;
                end else begin
                    nxt_t = t_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (t_q == CNT_W'(DRAIN_LEN - 1)) begin
                    nxt_state = S_STORE;
                    nxt_r     = '0;
                end else begin
                    nxt_t = t_q + 1'b1;
                end
            end
            S_STORE: begin
                if (res_ready) begin
                    if (r_q == RW'(A - 1)) nxt_state = S_NEXT;
                    else                   nxt_r = r_q + 1'b1;
                end
            end
            S_NEXT: begin
                nxt_state = S_CLEAR;
                if (col_q == TR_W'(T - 1)) begin
                    nxt_col = '0;
                    if (row_q == TR_W'(T - 1)) begin
                        nxt_row   = '0;
                        nxt_state = S_FIN;
                    end else begin
                        nxt_row = row_q + 1'b1;
                    end
                end else begin
                    nxt_col = col_q + 1'b1;
                end
            end
            S_FIN:   nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        av_n = '0;
        aa_n = '0;
        ba_n = '0;
        for (int i = 0; i < A; i++) begin
            if (nxt_state == S_FEED && nxt_t >= CNT_W'(i) &&
                nxt_t < CNT_W'(i + N)) begin
                av_n[i] = 1'b1;
                aa_n[i*ADDR_W +: ADDR_W] =
                    (ADDR_W'(nxt_row) * ADDR_W'(A) + ADDR_W'(i)) * ADDR_W'(N) +
                    ADDR_W'(nxt_t - CNT_W'(i));
                ba_n[i*ADDR_W +: ADDR_W] =
                    ADDR_W'(nxt_t - CNT_W'(i)) * ADDR_W'(N) +
                    ADDR_W'(nxt_col) * ADDR_W'(A) + ADDR_W'(i);
            end
        end
        raddr_n = (ADDR_W'(nxt_row) * ADDR_W'(A) + ADDR_W'(nxt_r)) * ADDR_W'(N) +
                  ADDR_W'(nxt_col) * ADDR_W'(A);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            r_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pe_clear <= 1'b0;
            pe_en    <= 1'b0;
            a_valid  <= '0;
            b_valid  <= '0;
            a_addr   <= '0;
            b_addr   <= '0;
            res_we   <= 1'b0;
            res_row  <= '0;
            res_addr <= '0;
            tile_idx <= '0;
        end else begin
            state_q  <= nxt_state;
            t_q      <= nxt_t;
            r_q      <= nxt_r;
            row_q    <= nxt_row;
            col_q    <= nxt_col;
            busy     <= nxt_state != S_IDLE;
            done     <= nxt_state == S_FIN;
            pe_clear <= nxt_state == S_CLEAR;
            pe_en    <= nxt_state == S_FEED || nxt_state == S_DRAIN;
            a_valid  <= av_n;
            b_valid  <= av_n;
            a_addr   <= aa_n;
            b_addr   <= ba_n;
            res_we   <= nxt_state == S_STORE;
            res_row  <= (nxt_state == S_STORE) ? nxt_r : '0;
            res_addr <= (nxt_state == S_STORE) ? raddr_n : '0;
            if (nxt_state == S_CLEAR)
                tile_idx <= TI_W'(nxt_row) * TI_W'(T) + TI_W'(nxt_col);
        end
    end

endmodule
